// File: rtl/scaler_mem_sequencer.sv
// scaler_mem_sequencer
// Memory-side sequencer for the scaling address generator (ULA). For each
// source pixel it fetches 1 or 4 pixels from a synchronous source ROM and
// latches them for the ULA. It then writes the result into the destination
// frame RAM and pulses the ULA counter-advance strobe. One frame runs per
// accepted start.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   start, algo_in        frame start request and algorithm select
//                         (001 replication, 010 decimation, 011 block average)
//   busy, done, err       frame status; err pulses with done on a rejected start
//   selected_algo         algorithm latched at start, drives the ULA
//   update_counters_en    one-cycle ULA counter-advance strobe
//   src_addr_in           base source address from the ULA
//   dest_addr_in          base destination address from the ULA
//   avg_pixel_in          ULA average of p00..p11
//   process_finished_in   ULA last-pixel flag
//   p00_out..p11_out      latched source pixels to the ULA
//   rom_addr, rom_data    source ROM port (data valid one cycle after address)
//   ram_waddr, ram_wdata,
//   ram_we                destination RAM write port
module scaler_mem_sequencer #(
    parameter int unsigned SRC_WIDTH  = 320,
    parameter int unsigned DEST_WIDTH = 640,
    parameter int unsigned ROM_AW     = 17,
    parameter int unsigned RAM_AW     = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        algo_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        selected_algo,
    output logic              update_counters_en,
    input  logic [ROM_AW-1:0] src_addr_in,
    input  logic [RAM_AW-1:0] dest_addr_in,
    input  logic [7:0]        avg_pixel_in,
    input  logic              process_finished_in,
    output logic [7:0]        p00_out,
    output logic [7:0]        p01_out,
    output logic [7:0]        p10_out,
    output logic [7:0]        p11_out,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [RAM_AW-1:0] ram_waddr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we
);

    localparam logic [2:0] ALGO_REP = 3'b001;
    localparam logic [2:0] ALGO_DEC = 3'b010;
    localparam logic [2:0] ALGO_AVG = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_ADV,
        S_CHK
    } state_t;

    state_t            r_state;
    logic [1:0]        r_k;        // fetch index
    logic [1:0]        r_w;        // replication write index

    logic [1:0]        w_last_k;
    logic              w_cap_en;
    logic [1:0]        w_cap_idx;
    logic              w_algo_ok;
    logic [ROM_AW-1:0] w_rom_next;
    logic [RAM_AW-1:0] w_ram_next;

    // Source offsets for the 2x2 neighbourhood: 0, +1, +W, +W+1
    function automatic logic [ROM_AW-1:0] src_off(input logic [1:0] idx);
        case (idx)
            2'd0:    src_off = '0;
            2'd1:    src_off = ROM_AW'(1);
            2'd2:    src_off = ROM_AW'(SRC_WIDTH);
            default: src_off = ROM_AW'(SRC_WIDTH + 1);
        endcase
    endfunction

    // Destination offsets for the 2x2 replication block
    function automatic logic [RAM_AW-1:0] dst_off(input logic [1:0] idx);
        case (idx)
            2'd0:    dst_off = '0;
            2'd1:    dst_off = RAM_AW'(1);
            2'd2:    dst_off = RAM_AW'(DEST_WIDTH);
            default: dst_off = RAM_AW'(DEST_WIDTH + 1);
        endcase
    endfunction

    // Fetch bookkeeping: last fetch index, and which pixel register takes
    // rom_data this cycle (the ROM returns data for the previous address).
    always_comb begin
        w_last_k   = (selected_algo == ALGO_AVG) ? 2'd3 : 2'd0;
        w_cap_en   = (r_state == S_CAP) || ((r_state == S_RD) && (r_k != 2'd0));
        w_cap_idx  = (r_state == S_CAP) ? w_last_k : (r_k - 2'd1);
        w_algo_ok  = (algo_in == ALGO_REP) || (algo_in == ALGO_DEC) || (algo_in == ALGO_AVG);
        w_rom_next = src_addr_in + src_off(r_k + 2'd1);
        w_ram_next = dest_addr_in + dst_off(r_w + 2'd1);
    end

    // Block average writes the ULA result; the other modes write p00.
    assign ram_wdata = (selected_algo == ALGO_AVG) ? avg_pixel_in : p00_out;

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state            <= S_IDLE;
            r_k                <= 2'd0;
            r_w                <= 2'd0;
            busy               <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
            selected_algo      <= 3'b000;
            update_counters_en <= 1'b0;
            p00_out            <= 8'd0;
            p01_out            <= 8'd0;
            p10_out            <= 8'd0;
            p11_out            <= 8'd0;
            rom_addr           <= '0;
            ram_waddr          <= '0;
            ram_we             <= 1'b0;
        end else begin
            done               <= 1'b0;
            err                <= 1'b0;
            update_counters_en <= 1'b0;

            if (w_cap_en) begin
                case (w_cap_idx)
                    2'd0:    p00_out <= rom_data;
                    2'd1:    p01_out <= rom_data;
                    2'd2:    p10_out <= rom_data;
                    default: p11_out <= rom_data;
                endcase
            end

            case (r_state)
                S_IDLE: begin
                    // A start coinciding with the done pulse is ignored
                    if (start && !done) begin
                        if (w_algo_ok) begin
                            selected_algo <= algo_in;
                            busy          <= 1'b1;
                            r_k           <= 2'd0;
                            rom_addr      <= src_addr_in;
                            r_state       <= S_RD;
                        end else begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    if (r_k == w_last_k) begin
                        r_state <= S_CAP;
                    end else begin
                        r_k      <= r_k + 2'd1;
                        rom_addr <= w_rom_next;
                    end
                end
                S_CAP: begin
                    ram_we    <= 1'b1;
                    ram_waddr <= dest_addr_in;
                    r_w       <= 2'd0;
                    r_state   <= S_WR;
                end
                S_WR: begin
                    if ((selected_algo == ALGO_REP) && (r_w != 2'd3)) begin
                        r_w       <= r_w + 2'd1;
                        ram_waddr <= w_ram_next;
                    end else begin
                        ram_we             <= 1'b0;
                        update_counters_en <= 1'b1;
                        r_state            <= S_ADV;
                    end
                end
                S_ADV: begin
                    r_state <= S_CHK;
                end
                S_CHK: begin
                    // ULA addresses have advanced by now
                    if (process_finished_in) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_k      <= 2'd0;
                        rom_addr <= src_addr_in;
                        r_state  <= S_RD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scaler_mem_sequencer.sv
// Testbench for scaler_mem_sequencer. Provides a synchronous ROM model and a
// small ULA model running a reduced frame of NPIX source pixels. A
// scoreboard queue holds the expected RAM writes.
module tb_scaler_mem_sequencer;

    localparam int NPIX  = 400;
    localparam int SRC_W = 320;
    localparam int DST_W = 640;
    localparam logic [2:0] A_REP = 3'b001;
    localparam logic [2:0] A_DEC = 3'b010;
    localparam logic [2:0] A_AVG = 3'b011;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  algo_in;
    logic        busy, done, err;
    logic [2:0]  selected_algo;
    logic        update_counters_en;
    logic [16:0] src_addr_in;
    logic [18:0] dest_addr_in;
    logic [7:0]  avg_pixel_in;
    logic        process_finished_in;
    logic [7:0]  p00_out, p01_out, p10_out, p11_out;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data;
    logic [18:0] ram_waddr;
    logic [7:0]  ram_wdata;
    logic        ram_we;

    scaler_mem_sequencer #(
        .SRC_WIDTH (SRC_W),
        .DEST_WIDTH(DST_W),
        .ROM_AW    (17),
        .RAM_AW    (19)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .algo_in            (algo_in),
        .busy               (busy),
        .done               (done),
        .err                (err),
        .selected_algo      (selected_algo),
        .update_counters_en (update_counters_en),
        .src_addr_in        (src_addr_in),
        .dest_addr_in       (dest_addr_in),
        .avg_pixel_in       (avg_pixel_in),
        .process_finished_in(process_finished_in),
        .p00_out            (p00_out),
        .p01_out            (p01_out),
        .p10_out            (p10_out),
        .p11_out            (p11_out),
        .rom_addr           (rom_addr),
        .rom_data           (rom_data),
        .ram_waddr          (ram_waddr),
        .ram_wdata          (ram_wdata),
        .ram_we             (ram_we)
    );

    always #5 clk = ~clk;

    // Synchronous source ROM
    logic [7:0] rom [0:131071];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // ULA address model
    function automatic logic [16:0] f_src(input logic [2:0] algo, input int i);
        case (algo)
            A_REP:   return 17'(i);
            A_DEC:   return 17'(2 * i);
            default: return 17'(2 * (i / 160) * SRC_W + 2 * (i % 160));
        endcase
    endfunction

    function automatic logic [18:0] f_dst(input logic [2:0] algo, input int i);
        if (algo == A_REP) return 19'(2 * (i / SRC_W) * DST_W + 2 * (i % SRC_W));
        return 19'(i);
    endfunction

    int   ula_idx;
    logic ula_fin;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ula_idx <= 0;
            ula_fin <= 1'b0;
        end else if (update_counters_en) begin
            if (ula_idx == NPIX - 1) begin
                ula_idx <= 0;
                ula_fin <= 1'b1;
            end else begin
                ula_idx <= ula_idx + 1;
                ula_fin <= 1'b0;
            end
        end
    end
    assign src_addr_in         = f_src(selected_algo, ula_idx);
    assign dest_addr_in        = f_dst(selected_algo, ula_idx);
    assign process_finished_in = ula_fin;
    assign avg_pixel_in = 8'((10'(p00_out) + 10'(p01_out) + 10'(p10_out) + 10'(p11_out)) >> 2);

    int n_pass  = 0;
    int n_total = 0;
    int exp_addr[$];
    int exp_data[$];
    int w_addr[$];
    int w_data[$];
    int w_t[$];
    int nwr;
    int ra;
    int rep_a[8] = '{0, 1, 640, 641, 2, 3, 642, 643};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    task automatic rom_linear();
        for (int a = 0; a < 131072; a++) rom[a] = 8'(a);
    endtask

    // Scoreboard: push every write the frame must produce
    task automatic build_expect(input logic [2:0] algo);
        int roff[4] = '{0, 1, DST_W, DST_W + 1};
        logic [16:0] s;
        int d;
        int sum;
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < NPIX; i++) begin
            s = f_src(algo, i);
            d = int'(f_dst(algo, i));
            if (algo == A_REP) begin
                for (int j = 0; j < 4; j++) begin
                    exp_addr.push_back(int'(19'(d + roff[j])));
                    exp_data.push_back(int'(rom[s]));
                end
            end else if (algo == A_DEC) begin
                exp_addr.push_back(d);
                exp_data.push_back(int'(rom[s]));
            end else begin
                sum = int'(rom[s]) + int'(rom[17'(s + 17'd1)]) +
                      int'(rom[17'(s + 17'(SRC_W))]) + int'(rom[17'(s + 17'(SRC_W + 1))]);
                exp_addr.push_back(d);
                exp_data.push_back(sum >> 2);
            end
        end
    endtask

    task automatic run_frame(input logic [2:0] algo, input int cpp, input int wpp,
                             input bit poke_busy, input bit poke_done);
        int t;
        int t_done;
        int n_w;
        int n_upd;
        int n_extra_done;
        build_expect(algo);
        w_addr.delete();
        w_data.delete();
        w_t.delete();
        n_w    = 0;
        n_upd  = 0;
        t_done = -1;
        @(negedge clk);
        algo_in = algo;
        start   = 1'b1;
        t       = 0;
        while (t_done < 0 && t < cpp * NPIX + 40) begin
            @(negedge clk);
            t++;
            start   = 1'b0;
            algo_in = algo;
            if (ram_we) begin
                w_addr.push_back(int'(ram_waddr));
                w_data.push_back(int'(ram_wdata));
                w_t.push_back(t);
                n_w++;
                if (exp_addr.size() == 0) begin
                    chk("wr_extra", 32'(n_w), 32'(wpp * NPIX));
                end else begin
                    chk("wr_addr", 32'(ram_waddr), 32'(exp_addr.pop_front()));
                    chk("wr_data", 32'(ram_wdata), 32'(exp_data.pop_front()));
                end
            end
            if (update_counters_en) n_upd++;
            if (done) begin
                t_done = t;
                chk("done_err", 32'(err), 32'(0));
                chk("done_busy", 32'(busy), 32'(0));
            end
            if (poke_busy && t == 20) begin
                start   = 1'b1;
                algo_in = A_REP;
            end
        end
        if (t_done < 0) chk("frame_done_seen", 32'(done), 32'(1));
        chk("frame_len", 32'(t_done >= cpp * NPIX - 1 && t_done <= cpp * NPIX + 1), 32'(1));
        chk("n_writes", 32'(n_w), 32'(wpp * NPIX));
        chk("exp_left", 32'(exp_addr.size()), 32'(0));
        chk("n_update", 32'(n_upd), 32'(NPIX));
        chk("sel_algo", 32'(selected_algo), 32'(algo));
        if (poke_done) start = 1'b1;
        n_extra_done = 0;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
            if (done || busy || ram_we) n_extra_done++;
        end
        chk("post_frame_idle", 32'(n_extra_done), 32'(0));
    endtask

    initial begin
        clk     = 1'b0;
        reset   = 1'b1;
        start   = 1'b0;
        algo_in = 3'b000;
        rom_linear();
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 32'({busy, done, err, selected_algo, update_counters_en, ram_we}), 32'(0));
        chk("rst_pix", {p00_out, p01_out, p10_out, p11_out}, 32'(0));
        chk("rst_rom_addr", 32'(rom_addr), 32'(0));
        chk("rst_ram", 32'({ram_waddr, ram_wdata}), 32'(0));
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_ctrl", 32'({busy, done, err, update_counters_en, ram_we}), 32'(0));

        // Decimation, start re-pulsed on the done cycle
        run_frame(A_DEC, 5, 1, 1'b0, 1'b1);
        chk("dec_w0_addr", 32'(w_addr[0]), 32'(0));
        chk("dec_w0_data", 32'(w_data[0]), 32'h00);
        chk("dec_w1_addr", 32'(w_addr[1]), 32'(1));
        chk("dec_w1_data", 32'(w_data[1]), 32'h02);
        chk("dec_w320_addr", 32'(w_addr[320]), 32'(320));
        chk("dec_w320_data", 32'(w_data[320]), 32'h80);

        // Rejected start: invalid algorithm
        ra = int'(rom_addr);
        @(negedge clk);
        algo_in = 3'b100;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rej_done", 32'(done), 32'(1));
        chk("rej_err", 32'(err), 32'(1));
        chk("rej_busy", 32'(busy), 32'(0));
        nwr = 0;
        repeat (5) begin
            @(negedge clk);
            if (ram_we || busy || done || err || int'(rom_addr) != ra) nwr++;
        end
        chk("rej_quiet", 32'(nwr), 32'(0));
        chk("rej_sel_algo", 32'(selected_algo), 32'(A_DEC));

        // Second decimation frame, start pulsed while busy
        run_frame(A_DEC, 5, 1, 1'b1, 1'b0);
        chk("dec2_w0_addr", 32'(w_addr[0]), 32'(0));
        chk("dec2_w1_data", 32'(w_data[1]), 32'h02);

        // Block average
        rom[0]   = 8'd10;
        rom[1]   = 8'd20;
        rom[320] = 8'd30;
        rom[321] = 8'd41;
        run_frame(A_AVG, 8, 1, 1'b0, 1'b0);
        chk("avg_w0_addr", 32'(w_addr[0]), 32'(0));
        chk("avg_w0_data", 32'(w_data[0]), 32'(25));
        chk("avg_w0_lat", 32'(w_t[0] - 1), 32'(5));

        // Replication
        rom_linear();
        rom[0] = 8'hAB;
        rom[1] = 8'hCD;
        run_frame(A_REP, 8, 4, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            chk("rep_addr", 32'(w_addr[j]), 32'(rep_a[j]));
            chk("rep_data", 32'(w_data[j]), (j < 4) ? 32'hAB : 32'hCD);
        end

        // Reset during the write phase of pixel 5
        @(negedge clk);
        algo_in = A_REP;
        start   = 1'b1;
        nwr     = 0;
        for (int t = 0; t < 500 && nwr < 21; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (ram_we) nwr++;
        end
        chk("abort_in_wr", 32'(ram_we), 32'(1));
        reset = 1'b1;
        #1;
        chk("abort_we", 32'(ram_we), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_pix", {p00_out, p01_out, p10_out, p11_out}, 32'(0));
        @(negedge clk);
        reset = 1'b0;
        nwr   = 0;
        repeat (20) begin
            @(negedge clk);
            if (ram_we || busy || update_counters_en) nwr++;
        end
        chk("abort_quiet", 32'(nwr), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/scaler_mem_sequencer.md
Name: scaler_mem_sequencer

Overview:
- Memory-side counterpart of the scaling address generator (ULA).
- Per source pixel it reads the addressed pixel(s) from the synchronous source ROM, presents them as p00..p11 to the ULA, and writes the result into the destination frame RAM.
- After each pixel it pulses the ULA's counter-advance strobe.
- Runs one full frame per start command and reports completion.

Parameters:
- SRC_WIDTH, 320, source line pitch in pixels; used for the +W row offset.
- DEST_WIDTH, 640, destination line pitch in pixels; used for replication writes.
- ROM_AW, 17, source ROM address width.
- RAM_AW, 19, destination RAM address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle frame start request.
- algo_in  in  3  algorithm: 001 replication, 010 decimation, 011 block average.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse at frame end or on rejected start.
- err  out  1  one-cycle pulse, together with done, when algo_in is invalid.
- selected_algo  out  3  algorithm latched at start; drives the ULA.
- update_counters_en  out  1  one-cycle ULA counter-advance strobe.
- src_addr_in  in  ROM_AW  base source address from the ULA.
- dest_addr_in  in  RAM_AW  base destination address from the ULA.
- avg_pixel_in  in  8  ULA average of p00..p11.
- process_finished_in  in  1  ULA last-pixel flag.
- p00_out, p01_out, p10_out, p11_out  out  8 each  latched pixels, to the ULA.
- rom_addr  out  ROM_AW  ROM read address; data returns one cycle later.
- rom_data  in  8  ROM read data.
- ram_waddr  out  RAM_AW  RAM write address.
- ram_wdata  out  8  RAM write data.
- ram_we  out  1  RAM write enable.

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset mid-frame aborts immediately with no further writes. The ULA shares the same reset.
- States: IDLE, RD, CAP, WR, ADV, CHK.
- IDLE:
  - start with algo_in in {001,010,011}: latch selected_algo, busy<=1, k<=0, go to RD.
  - start with any other algo_in: done=err=1 for one cycle, stay in IDLE, selected_algo unchanged.
  - start while busy is ignored.
- RD (one cycle per fetch index k):
  - rom_addr = src_addr_in + offset[k]; offsets are {0, 1, SRC_WIDTH, SRC_WIDTH+1} for k = 0..3.
  - Addresses are truncated modulo 2^ROM_AW.
  - When k>0, rom_data is latched into p[k-1].
  - Number of fetches N: 1 for replication and decimation (p00 only), 4 for block average.
  - After index N-1, go to CAP.
- CAP: latch rom_data into p[N-1]. Pixels not fetched hold their previous value. Go to WR.
- WR:
  - Replication: 4 consecutive cycles with ram_we=1, wdata=p00_out, waddr = dest_addr_in + {0, 1, DEST_WIDTH, DEST_WIDTH+1}, in that order.
  - Decimation: 1 cycle, wdata=p00_out, waddr=dest_addr_in.
  - Block average: 1 cycle, wdata=avg_pixel_in, waddr=dest_addr_in.
  - Write addresses are truncated modulo 2^RAM_AW. ram_we is 0 in every other state.
  - Go to ADV.
- ADV: update_counters_en=1 for exactly one cycle. Go to CHK.
- CHK (update_counters_en=0):
  - process_finished_in=1: busy<=0, done=1 for one cycle, go to IDLE.
  - Otherwise: k<=0, go to RD. The ULA addresses are already updated.
- Cycles per source pixel: replication 8, decimation 5, block average 8. Full 320x240 frame: 614400 / 384000 / 614400 cycles from the start cycle to the done cycle, ±1.
- The ULA counters wrap to origin at frame end, so back-to-back frames need no extra clear.
- start asserted in the same cycle as done (CHK→IDLE) is ignored; start is accepted from the next cycle.

Test Plan:
- Reset checks:
  - Reset, then idle: every output is 0.
  - Assert reset during WR of pixel 5: ram_we drops in the same cycle and busy=0 after reset.
- Decimation, ROM[a]=a[7:0]:
  - Write #0 is addr 0, data 0x00.
  - Write #1 is addr 1, data 0x02.
  - Write at dest 320 takes data from src 640, i.e. 0x80.
  - Exactly 76800 writes total, then one done pulse.
- Block average, ROM[0]=10, ROM[1]=20, ROM[320]=30, ROM[321]=41: first write is addr 0, data 25 (sum 101>>2), issued 5 cycles after RD entry.
- Replication, ROM[0]=0xAB, ROM[1]=0xCD:
  - Pixel 0 writes 0xAB to dest 0, 1, 640, 641, in order.
  - Pixel 1 writes 0xCD to dest 2, 3, 642, 643.
  - 307200 writes total.
- start with algo_in=3'b100: done=err=1 for one cycle, busy stays 0, no ROM or RAM activity.
- Frame protocol:
  - start pulsed while busy: no effect.
  - After done, a second start with the same algo repeats an identical write sequence from dest 0.
  - update_counters_en pulses exactly 76800 times per frame.
